// File: rtl/hazard_unit_mc.sv
// ---------------------------------------------------------------------------
// hazard_unit_mc
//
// Hazard unit for the 5-stage RISC-V pipeline. Sits beside the datapath and
// produces the stage enables/flushes and the EX operand-forwarding selects.
//
// Features:
//   - operand forwarding into EX (M result or M PC+4 beats W result)
//   - load-use stall, never triggered by x0
//   - branch/jump flush, which wins over the load-use stall
//   - multi-cycle EX occupancy counter (MUL/DIV): stalls F/D/E, bubbles M
//   - saturating performance counters for stall and flush cycles
//
// Parameters:
//   REG_AW : register-address width
//   MC_LAT : total EX cycles of a multi-cycle op (>=1, 1 = never busy)
//   CNT_W  : performance-counter width
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   RegWriteM/W              : M/W-stage instruction writes rd
//   ResultSrcE/M             : result source (E: 01 = load, M: 11 = PC+4)
//   PCSrcE                   : E-stage redirect, non-zero = taken
//   McStartE                 : E holds a multi-cycle op
//   Rs1D/Rs2D, Rs1E/Rs2E     : D- and E-stage source registers
//   RdE/RdM/RdW              : destination registers in E, M, W
//   StallF/D/E               : hold the stage register
//   FlushD/E/M               : bubble into the stage register
//   ForwardAE/BE             : 00 regfile, 01 W result, 10 M ALU, 11 M PC+4
//   McBusy                   : multi-cycle op occupying E
//   StallCnt/FlushCnt        : saturating StallF / FlushD cycle counts
// ---------------------------------------------------------------------------
module hazard_unit_mc #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [1:0]        ResultSrcE,
  input  logic [1:0]        ResultSrcM,
  input  logic [1:0]        PCSrcE,
  input  logic              McStartE,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  localparam int             MCW     = $clog2(MC_LAT) + 1;
  localparam logic [MCW-1:0] MC_LOAD = MCW'(MC_LAT - 1);
  localparam logic [MCW-1:0] MC_ONE  = MCW'(1);
  localparam bit             MC_EN   = (MC_LAT > 1);

  logic [MCW-1:0] mcCnt;
  logic           mcStart;
  logic           mcStall;
  logic           redir;
  logic           loadUse;

  // Forwarding select for one EX source; M wins over W, x0 never forwards.
  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdM,
    input logic              regWriteM,
    input logic [1:0]        resultSrcM,
    input logic [REG_AW-1:0] rdW,
    input logic              regWriteW
  );
    if (rs != '0 && rs == rdM && regWriteM)
      return (resultSrcM == 2'b11) ? 2'b11 : 2'b10;
    else if (rs != '0 && rs == rdW && regWriteW)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, ResultSrcM, RdW, RegWriteW);
  assign ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, ResultSrcM, RdW, RegWriteW);

  // A redirect is only honoured when no multi-cycle op owns E.
  assign redir   = (PCSrcE != 2'b00) && (mcCnt == '0);
  assign loadUse = (ResultSrcE == 2'b01) && (RdE != '0) &&
                   ((Rs1D == RdE) || (Rs2D == RdE));

  // Start only from idle: on the completing cycle (mcCnt==1) the op's own
  // McStartE is still high but must not re-arm the counter.
  assign mcStart = McStartE && (mcCnt == '0) && MC_EN && (PCSrcE == 2'b00);
  assign mcStall = mcStart || (mcCnt > MC_ONE);
  assign McBusy  = mcStall || (mcCnt == MC_ONE);

  assign StallF = mcStall || (loadUse && !redir);
  assign StallD = StallF;
  assign StallE = mcStall;
  assign FlushM = mcStall;
  assign FlushD = redir && !mcStall;
  assign FlushE = (redir || loadUse) && !mcStall;

  // NOTE: only control state lives in flops here, and all of it is reset;
  // state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcCnt    <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (mcStart)
        mcCnt <= MC_LOAD;
      else if (mcCnt != '0)
        mcCnt <= mcCnt - MC_ONE;

      if (StallF && StallCnt != '1)
        StallCnt <= StallCnt + CNT_W'(1);
      if (FlushD && FlushCnt != '1)
        FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Next-generation hazard unit for the 5-stage RISC-V pipeline, parametrised in register-address width and multi-cycle EX latency. It provides:
- operand forwarding into EX;
- load-use stall with a correct x0 exclusion;
- branch/jump flush that takes priority over the load-use stall;
- a multi-cycle EX occupancy counter for MUL/DIV that stalls F/D/E and bubbles M;
- saturating stall and flush performance counters.

It sits beside the datapath, driving stage enables, flushes and EX operand mux selects.

Parameters:
REG_AW, 5, register-address width.
MC_LAT, 4, total EX cycles for a multi-cycle op. Must be ≥1; 1 means never busy.
CNT_W, 16, perf-counter width.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
RegWriteM  in  1  M-stage instruction writes rd
RegWriteW  in  1  W-stage instruction writes rd
ResultSrcE  in  2  E result source; 01 = load
ResultSrcM  in  2  M result source; 11 = PC+4
PCSrcE  in  2  E redirect; 00 = none, any other value = taken
McStartE  in  1  E holds a multi-cycle op; stays high while that op occupies E
Rs1D, Rs2D  in  REG_AW  D-stage sources
Rs1E, Rs2E  in  REG_AW  E-stage sources
RdE, RdM, RdW  in  REG_AW  destinations in E, M, W
StallF, StallD, StallE  out  1  hold the stage register
FlushD, FlushE, FlushM  out  1  bubble into the stage register
ForwardAE, ForwardBE  out  2  00 = regfile, 01 = W result, 10 = M ALU result, 11 = M PC+4
McBusy  out  1  multi-cycle op occupying E
StallCnt  out  CNT_W  saturating count of cycles with StallF=1
FlushCnt  out  CNT_W  saturating count of cycles with FlushD=1

Behaviour:
- Reset (async, rst=1): mc_cnt=0, StallCnt=0, FlushCnt=0. All outputs take their combinational values with mc_cnt=0.

Forwarding (per source, shown for A; B is identical with Rs2E):
- If Rs1E!=0, Rs1E==RdM and RegWriteM: 11 when ResultSrcM==11, else 10.
- Else if Rs1E!=0, Rs1E==RdW and RegWriteW: 01.
- Else 00.
- M has priority over W.

Multi-cycle counter mc_cnt (width ceil(log2(MC_LAT))+1):
- mc_start = McStartE && mc_cnt==0 && MC_LAT>1 && PCSrcE==00.
- mc_stall = mc_start || mc_cnt>1.
- Next-state: mc_start loads MC_LAT-1; otherwise decrement when mc_cnt!=0.
- On the cycle mc_cnt==1 the op completes: no stall, E advances, counter goes to 0, and the same op's McStartE does not restart it.
- Stall cycles per op = MC_LAT-1.
- McBusy = mc_stall || mc_cnt==1.

Load-use:
- lw = ResultSrcE==01 && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).

Redirect:
- redir = PCSrcE!=00.

Output equations:
- StallF = StallD = mc_stall || (lw && !redir).
- StallE = mc_stall.
- FlushM = mc_stall.
- FlushD = redir && !mc_stall.
- FlushE = (redir || lw) && !mc_stall.

Priority:
- mc_stall > redir > lw.
- While mc_cnt!=0, PCSrcE is ignored.
- Redirect in the same cycle as a load-use releases the stall and flushes D and E, so the wrong-path instruction is not held.

Counters:
- Each counter increments by 1 per cycle its qualifier is high.
- Each holds at all-ones; no wrap.

Test Plan:
- rst pulsed mid-op (MC_LAT=4, mc_cnt=2) → next cycle McBusy=0, StallE=0, counters 0, with no clk edge needed.
- Rs1E=Rs2E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 → ForwardAE=ForwardBE=10. Same with ResultSrcM=11 → 11. Rs1E=0 with RdM=0 → 00.
- ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=00 → StallF=StallD=FlushE=1 for one cycle. RdE=0, Rs1D=0 → no stall. Same load-use with PCSrcE=01 → StallF=0, FlushD=FlushE=1.
- MC_LAT=4, McStartE held for 4 cycles → StallE/StallF/FlushM=1 for exactly 3 cycles and McBusy=1 for 4. A back-to-back second op restarts on the 5th cycle.
- MC_LAT=1, McStartE=1 → no stall, McBusy=0.
- CNT_W=4 with StallF held for 20 cycles → StallCnt saturates at 15. FlushCnt counts redirect cycles only.
